mem_slice: RTL and testbench
============================

Name: mem_slice

Overview:
- MEM pipeline stage of the 16-bit 5-stage CPU. Sits downstream of the EX slice and consumes its result, flags, M and WB controls.
- Performs data-memory load/store over a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- Holds the architectural flag register (zero, neg, overflow) used by branch resolution.
- Presents a registered writeback bundle to the WB stage.

Parameters:
- DW, 16, data/result width
- AW, 16, data memory address width; the address is result[AW-1:0]
- RW, 4, register-index width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  EX stage presents an instruction
- in_ready  output  1  stage can accept; low means stall upstream
- WB_in  input  1  instruction writes the register file
- M_in  input  3  [2]=MemRead, [1]=MemWrite, [0]=FlagWrite
- result  input  DW  ALU result; memory address for loads and stores
- store_data  input  DW  store data (r1data)
- rd  input  RW  destination register
- flags_in  input  3  {zero, neg, overflow} from the ALU
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  AW  access address
- mem_wdata  output  DW  write data
- mem_ack  input  1  access complete; read data valid on the same cycle
- mem_rdata  input  DW  read data
- flags  output  3  architectural flag register
- wb_valid  output  1  one-cycle retire pulse to WB
- wb_we  output  1  register write enable
- wb_rd  output  RW  writeback register
- wb_data  output  DW  writeback data

Behaviour:
- Reset: state IDLE; in_ready=1; mem_req, mem_we, wb_valid, wb_we = 0; mem_addr, mem_wdata, wb_rd, wb_data, flags = 0.
- States: IDLE, ACCESS. in_ready = (state==IDLE).
- Accept: in_valid && in_ready on cycle N.
- If FlagWrite: flags <= flags_in at N+1, independent of any memory access.
- Non-memory op (MemRead=MemWrite=0):
  - wb_valid=1 at N+1 with wb_data=result.
  - State stays IDLE, so back-to-back accepts give one retire per cycle.
- Memory op:
  - At N+1: state=ACCESS, mem_req=1, mem_addr=result, mem_we=MemWrite, mem_wdata=store_data. All are registered and held stable until ack.
  - mem_ack is sampled only while in ACCESS; an ack is allowed on the first ACCESS cycle.
  - On the ack cycle A: capture mem_rdata. At A+1: mem_req=0, state=IDLE, wb_valid=1, in_ready=1.
  - Load: wb_data = captured rdata. Store: wb_data = address.
- wb_we = WB_in && !MemWrite && (rd != 0). Register 0 is never written.
- MemRead and MemWrite both set: handled as a store; no register write.
- mem_ack outside ACCESS is ignored.
- wb_valid lasts exactly one cycle per accepted instruction. wb_rd, wb_data and wb_we hold their values until the next retire.
- Reset asserted mid-access: asynchronously drop mem_req and return to IDLE. The transaction is abandoned, no retire occurs, and a late ack is ignored.
- in_valid while in_ready=0: the upstream stage must hold its inputs; this block does not sample them.

Optional Feature:
- Macro MEM_FWD_EN.
- When defined, add outputs fwd_valid (1), fwd_rd (RW) and fwd_data (DW) for the EX forwarding unit:
  - fwd_valid is combinationally high when wb_valid && wb_we; it carries wb_rd and wb_data.
  - In ACCESS for a load with a register write, fwd_valid stays 0 and an extra output fwd_pending=1 lets EX interlock.
- When undefined, these ports do not exist and no forwarding logic is built.

Test Plan:
- ADD, result=0x1234, rd=3, WB_in=1, M=000 at cycle N -> wb_valid at N+1, wb_data=0x1234, wb_rd=3, wb_we=1, no mem_req.
- Load, address=0x0040, ack 3 cycles after mem_req rises, rdata=0xBEEF, rd=5 -> mem_req high for 3 cycles with mem_addr=0x0040, mem_we=0; in_ready low the same span; wb_valid one cycle after ack with wb_data=0xBEEF.
- Store, address=0x0010, store_data=0xA5A5, same-cycle ack -> one-cycle mem_req with mem_we=1 and mem_wdata=0xA5A5; wb_valid with wb_we=0.
- FlagWrite with flags_in=3'b100 followed by an instruction with FlagWrite=0 -> flags=100 and still 100 after the second instruction; an op with WB_in=1, rd=0 -> wb_we=0.
- rst pulsed during ACCESS, then stray mem_ack -> mem_req falls immediately, no wb_valid, in_ready=1, flags=0.
- MEM_FWD_EN: ADD retires with rd=2 -> fwd_valid=1 and fwd_rd=2 that cycle; a pending load to rd=4 -> fwd_pending=1 until ack.

Source files
------------

// File: rtl/mem_slice.sv
// rtl/mem_slice.sv - MEM pipeline stage: data-memory req/ack access, flag register, registered writeback.
// Optional EX forwarding outputs are built when MEM_FWD_EN is defined.
module mem_slice #(
   parameter int DW = 16,
   parameter int AW = 16,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          WB_in,
   input  logic [2:0]    M_in,
   input  logic [DW-1:0] result,
   input  logic [DW-1:0] store_data,
   input  logic [RW-1:0] rd,
   input  logic [2:0]    flags_in,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic [2:0]    flags,
   output logic          wb_valid,
   output logic          wb_we,
   output logic [RW-1:0] wb_rd,
`ifdef MEM_FWD_EN
   output logic          fwd_valid,
   output logic [RW-1:0] fwd_rd,
   output logic [DW-1:0] fwd_data,
   output logic          fwd_pending,
`endif
   output logic [DW-1:0] wb_data
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [2:0]    flags_q, flags_d;
   logic          wb_valid_q, wb_valid_d;
   logic          wb_we_q, wb_we_d;
   logic [RW-1:0] wb_rd_q, wb_rd_d;
   logic [DW-1:0] wb_data_q, wb_data_d;
   // Writeback fields of the outstanding memory op, applied at retire.
   logic          pend_we_q, pend_we_d;
   logic [RW-1:0] pend_rd_q, pend_rd_d;

   logic          reg_we_c;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      flags_d     = flags_q;
      wb_valid_d  = 1'b0;
      wb_we_d     = wb_we_q;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      pend_we_d   = pend_we_q;
      pend_rd_d   = pend_rd_q;
      reg_we_c    = WB_in && !M_in[1] && (rd != '0);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (M_in[0]) flags_d = flags_in;
               if (M_in[2] || M_in[1]) begin
                  state_d     = ACCESS;
                  mem_req_d   = 1'b1;
                  mem_we_d    = M_in[1];
                  mem_addr_d  = result[AW-1:0];
                  mem_wdata_d = store_data;
                  pend_we_d   = reg_we_c;
                  pend_rd_d   = rd;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = reg_we_c;
                  wb_rd_d    = rd;
                  wb_data_d  = result;
               end
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               wb_valid_d = 1'b1;
               wb_we_d    = pend_we_q;
               wb_rd_d    = pend_rd_q;
               // Stores retire the access address; loads retire the read data.
               wb_data_d  = mem_we_q ? DW'(mem_addr_q) : mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         flags_q     <= '0;
         wb_valid_q  <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         pend_we_q   <= 1'b0;
         pend_rd_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         flags_q     <= flags_d;
         wb_valid_q  <= wb_valid_d;
         wb_we_q     <= wb_we_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         pend_we_q   <= pend_we_d;
         pend_rd_q   <= pend_rd_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign flags     = flags_q;
   assign wb_valid  = wb_valid_q;
   assign wb_we     = wb_we_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;

`ifdef MEM_FWD_EN
   assign fwd_valid   = wb_valid_q && wb_we_q;
   assign fwd_rd      = wb_rd_q;
   assign fwd_data    = wb_data_q;
   // A load still in flight cannot forward yet; EX must interlock on its rd.
   assign fwd_pending = (state_q == ACCESS) && !mem_we_q && pend_we_q;
`endif

endmodule

// File: tb/tb_mem_slice.sv
// tb/tb_mem_slice.sv - Self-checking bench for mem_slice with randomized ops and a behavioural model.
// Forwarding checks are compiled in when MEM_FWD_EN is defined.
module tb_mem_slice;
   localparam int DW = 16;
   localparam int AW = 16;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          WB_in = 1'b0;
   logic [2:0]    M_in = '0;
   logic [DW-1:0] result = '0;
   logic [DW-1:0] store_data = '0;
   logic [RW-1:0] rd = '0;
   logic [2:0]    flags_in = '0;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic [2:0]    flags;
   logic          wb_valid;
   logic          wb_we;
   logic [RW-1:0] wb_rd;
   logic [DW-1:0] wb_data;
`ifdef MEM_FWD_EN
   logic          fwd_valid;
   logic [RW-1:0] fwd_rd;
   logic [DW-1:0] fwd_data;
   logic          fwd_pending;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [2:0] flags_exp = '0;

   always #5 clk = ~clk;

   mem_slice #(.DW(DW), .AW(AW), .RW(RW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .WB_in(WB_in), .M_in(M_in), .result(result), .store_data(store_data),
      .rd(rd), .flags_in(flags_in), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .flags(flags), .wb_valid(wb_valid), .wb_we(wb_we),
      .wb_rd(wb_rd),
`ifdef MEM_FWD_EN
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .fwd_pending(fwd_pending),
`endif
      .wb_data(wb_data)
   );

   function automatic logic exp_we(input logic wb, input logic [2:0] m, input logic [RW-1:0] r);
      return wb && !m[1] && (r != 0);
   endfunction

   task automatic drive_op(input logic wb, input logic [2:0] m, input logic [DW-1:0] res,
                           input logic [DW-1:0] sd, input logic [RW-1:0] r, input logic [2:0] fi);
      in_valid = 1'b1; WB_in = wb; M_in = m; result = res; store_data = sd; rd = r; flags_in = fi;
      if (m[0]) flags_exp = fi;
   endtask

   task automatic drive_idle();
      in_valid = 1'b0; WB_in = 1'b0; M_in = '0; result = '0; store_data = '0; rd = '0; flags_in = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({in_ready, mem_req, mem_we, wb_valid, wb_we, flags, wb_rd, wb_data, mem_addr, mem_wdata}
          !== {1'b1, 4'b0, 3'b0, 4'b0, 16'h0, 16'h0, 16'h0}) begin
         n_bad++;
         $display("FAIL reset_state got rdy=%b req=%b we=%b wbv=%b wbwe=%b fl=%b rd=%h d=%h a=%h wd=%h want rdy=1 rest=0",
                  in_ready, mem_req, mem_we, wb_valid, wb_we, flags, wb_rd, wb_data, mem_addr, mem_wdata);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      flags_exp = '0;
   endtask

   task automatic test_add();
      @(negedge clk);
      drive_op(1'b1, 3'b000, 16'h1234, 16'h0, 4'd3, 3'b010);
      @(negedge clk);
      drive_idle();
      n_cmp++;
      if ({wb_valid, wb_we, wb_rd, wb_data, mem_req, in_ready} !== {1'b1, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL add_retire got v=%b we=%b rd=%h d=%h req=%b rdy=%b want 1 1 3 1234 0 1",
                  wb_valid, wb_we, wb_rd, wb_data, mem_req, in_ready);
      end
`ifdef MEM_FWD_EN
      n_cmp++;
      if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 4'd3, 16'h1234}) begin
         n_bad++;
         $display("FAIL add_fwd got v=%b rd=%h d=%h want 1 3 1234", fwd_valid, fwd_rd, fwd_data);
      end
`endif
      @(negedge clk);
      n_cmp++;
      if ({wb_valid, wb_data, wb_rd} !== {1'b0, 16'h1234, 4'd3}) begin
         n_bad++;
         $display("FAIL add_pulse_hold got v=%b d=%h rd=%h want 0 1234 3", wb_valid, wb_data, wb_rd);
      end
   endtask

   task automatic test_load();
      int hi = 0;
      @(negedge clk);
      drive_op(1'b1, 3'b100, 16'h0040, 16'h0, 4'd5, 3'b000);
      @(negedge clk);
      drive_idle();
      for (int k = 1; k <= 3; k++) begin
         if (mem_req && !in_ready && mem_addr == 16'h0040 && !mem_we && !wb_valid) hi++;
`ifdef MEM_FWD_EN
         n_cmp++;
         if ({fwd_pending, fwd_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL load_fwd_pending cyc=%0d got p=%b v=%b want 1 0", k, fwd_pending, fwd_valid);
         end
`endif
         if (k == 3) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
         @(negedge clk);
         mem_ack = 1'b0;
      end
      n_cmp++;
      if (hi !== 3) begin
         n_bad++;
         $display("FAIL load_req_span got %0d good cycles want 3", hi);
      end
      n_cmp++;
      if ({wb_valid, wb_we, wb_rd, wb_data, mem_req, in_ready} !== {1'b1, 1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL load_retire got v=%b we=%b rd=%h d=%h req=%b rdy=%b want 1 1 5 beef 0 1",
                  wb_valid, wb_we, wb_rd, wb_data, mem_req, in_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (wb_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL load_pulse got %b want 0", wb_valid);
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      drive_op(1'b1, 3'b010, 16'h0010, 16'hA5A5, 4'd7, 3'b000);
      @(negedge clk);
      drive_idle();
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, in_ready} !== {1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b0}) begin
         n_bad++;
         $display("FAIL store_req got req=%b we=%b a=%h wd=%h rdy=%b want 1 1 0010 a5a5 0",
                  mem_req, mem_we, mem_addr, mem_wdata, in_ready);
      end
      mem_ack = 1'b1; mem_rdata = 16'h1111;
      @(negedge clk);
      mem_ack = 1'b0;
      n_cmp++;
      if ({mem_req, wb_valid, wb_we, wb_data, in_ready} !== {1'b0, 1'b1, 1'b0, 16'h0010, 1'b1}) begin
         n_bad++;
         $display("FAIL store_retire got req=%b v=%b we=%b d=%h rdy=%b want 0 1 0 0010 1",
                  mem_req, wb_valid, wb_we, wb_data, in_ready);
      end
   endtask

   task automatic test_flags_rd0();
      @(negedge clk);
      drive_op(1'b1, 3'b001, 16'h0001, 16'h0, 4'd2, 3'b100);
      @(negedge clk);
      n_cmp++;
      if (flags !== 3'b100) begin
         n_bad++;
         $display("FAIL flag_write got %b want 100", flags);
      end
      drive_op(1'b1, 3'b000, 16'h0002, 16'h0, 4'd0, 3'b011);
      @(negedge clk);
      drive_idle();
      n_cmp++;
      if ({flags, wb_valid, wb_we, wb_rd} !== {3'b100, 1'b1, 1'b0, 4'd0}) begin
         n_bad++;
         $display("FAIL flag_hold_rd0 got fl=%b v=%b we=%b rd=%h want 100 1 0 0", flags, wb_valid, wb_we, wb_rd);
      end
   endtask

   task automatic test_stray_ack();
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clk);
      mem_ack = 1'b0;
      n_cmp++;
      if ({wb_valid, mem_req, in_ready} !== 3'b001) begin
         n_bad++;
         $display("FAIL idle_ack got v=%b req=%b rdy=%b want 0 0 1", wb_valid, mem_req, in_ready);
      end
   endtask

   task automatic test_reset_mid_access();
      int wbs = 0;
      @(negedge clk);
      drive_op(1'b1, 3'b101, 16'h0080, 16'h0, 4'd6, 3'b111);
      @(negedge clk);
      drive_idle();
      n_cmp++;
      if ({mem_req, flags} !== {1'b1, 3'b111}) begin
         n_bad++;
         $display("FAIL rma_pre got req=%b fl=%b want 1 111", mem_req, flags);
      end
      #1 rst = 1'b1;
      #1;
      flags_exp = '0;
      n_cmp++;
      if ({mem_req, in_ready, flags, wb_valid} !== {1'b0, 1'b1, 3'b000, 1'b0}) begin
         n_bad++;
         $display("FAIL rma_async got req=%b rdy=%b fl=%b v=%b want 0 1 000 0", mem_req, in_ready, flags, wb_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 16'h5555;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (wb_valid) wbs++;
      end
      n_cmp++;
      if ({wbs[1:0], in_ready, mem_req, flags} !== {2'd0, 1'b1, 1'b0, 3'b000}) begin
         n_bad++;
         $display("FAIL rma_late_ack got wbs=%0d rdy=%b req=%b fl=%b want 0 1 0 000", wbs, in_ready, mem_req, flags);
      end
   endtask

   task automatic test_back_to_back(input int n);
      logic          e_we;
      logic [RW-1:0] e_rd;
      logic [DW-1:0] e_data;
      e_we = 1'b0; e_rd = '0; e_data = '0;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_cmp++;
            if ({wb_valid, wb_we, wb_rd, wb_data, flags, in_ready, mem_req} !==
                {1'b1, e_we, e_rd, e_data, flags_exp, 1'b1, 1'b0}) begin
               n_bad++;
               $display("FAIL b2b[%0d] got v=%b we=%b rd=%h d=%h fl=%b want 1 %b %h %h %b",
                        i, wb_valid, wb_we, wb_rd, wb_data, flags, e_we, e_rd, e_data, flags_exp);
            end
         end
         if (i < n) begin
            logic          wb;
            logic [2:0]    m;
            logic [DW-1:0] res;
            logic [RW-1:0] r;
            wb = 1'($urandom); m = {2'b00, 1'($urandom)}; res = 16'($urandom); r = 4'($urandom);
            drive_op(wb, m, res, 16'($urandom), r, 3'($urandom));
            e_we = exp_we(wb, m, r); e_rd = r; e_data = res;
         end else begin
            drive_idle();
         end
      end
   endtask

   task automatic test_random_mem(input int n);
      for (int i = 0; i < n; i++) begin
         logic          wb;
         logic [2:0]    m;
         logic [DW-1:0] res, sd, rdv, e_data;
         logic [RW-1:0] r;
         int            lat, good;
         wb = 1'($urandom); r = 4'($urandom); res = 16'($urandom); sd = 16'($urandom); rdv = 16'($urandom);
         m[2:1] = 2'($urandom_range(1, 3)); m[0] = 1'($urandom);
         lat = $urandom_range(1, 4);
         good = 0;
         @(negedge clk);
         drive_op(wb, m, res, sd, r, 3'($urandom));
         @(negedge clk);
         drive_idle();
         for (int k = 1; k <= lat; k++) begin
            if (mem_req && !in_ready && !wb_valid && mem_addr == res && mem_we == m[1] && mem_wdata == sd
`ifdef MEM_FWD_EN
                && fwd_pending == (!m[1] && exp_we(wb, m, r))
`endif
                ) good++;
            if (k == lat) begin mem_ack = 1'b1; mem_rdata = rdv; end
            @(negedge clk);
            mem_ack = 1'b0;
         end
         n_cmp++;
         if (good != lat) begin
            n_bad++;
            $display("FAIL rmem[%0d]_access got %0d good cycles want %0d (m=%b a=%h)", i, good, lat, m, res);
         end
         e_data = m[1] ? res : rdv;
         n_cmp++;
         if ({wb_valid, wb_we, wb_rd, wb_data, flags, mem_req, in_ready} !==
             {1'b1, exp_we(wb, m, r), r, e_data, flags_exp, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL rmem[%0d]_retire got v=%b we=%b rd=%h d=%h fl=%b want 1 %b %h %h %b",
                     i, wb_valid, wb_we, wb_rd, wb_data, flags, exp_we(wb, m, r), r, e_data, flags_exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load();
      test_store();
      test_flags_rd0();
      test_stray_ack();
      test_reset_mid_access();
      test_back_to_back(40);
      test_random_mem(30);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
